// File: rtl/gcd_li3_if.sv
// Request/response bundle between a CPU custom-instruction port and a CFU.
// master: CPU side. It drives the request fields and resp_ready.
// slave : CFU side. It drives req_ready and the response fields.
//   req_valid/req_ready    request handshake
//   req_id/req_func_id     request tag and function select
//   req_data0/req_data1    operands
//   resp_valid/resp_ready  response handshake
//   resp_id/resp_data      echoed tag and result
//   resp_err               unsupported-function flag
interface gcd_li3_if #(
  parameter int CFU_FUNCTION_ID_W = 1,
  parameter int CFU_REQ_RESP_ID_W = 6,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = CFU_REQ_DATA_W
);
  logic                         req_valid;
  logic                         req_ready;
  logic [CFU_REQ_RESP_ID_W-1:0] req_id;
  logic [CFU_FUNCTION_ID_W-1:0] req_func_id;
  logic [CFU_REQ_DATA_W-1:0]    req_data0;
  logic [CFU_REQ_DATA_W-1:0]    req_data1;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [CFU_REQ_RESP_ID_W-1:0] resp_id;
  logic [CFU_RESP_DATA_W-1:0]   resp_data;
  logic                         resp_err;

  modport master (
    output req_valid, req_id, req_func_id, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_id, req_func_id, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/gcd_li3.sv
// Latency-insensitive GCD custom function unit.
// The unit takes one tagged request at a time and runs binary (Stein) GCD
// at one step per cycle. It returns a tagged response through valid/ready.
// Function 0 is GCD. Any other function gets resp_err=1 and resp_data=0.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    gcd_li3_if.slave. It carries the request and response handshakes.
// All outputs are decoded from registered state, so no input reaches an
// output combinationally.
module gcd_li3 #(
  parameter int CFU_FUNCTION_ID_W = 1,
  parameter int CFU_REQ_RESP_ID_W = 6,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = CFU_REQ_DATA_W
) (
  input  logic       clk,
  input  logic       rst_n,
  gcd_li3_if.slave   bus
);
  localparam int W   = CFU_REQ_DATA_W;
  localparam int K_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [W-1:0]                 a_q, a_d;
  logic [W-1:0]                 b_q, b_d;
  logic [K_W-1:0]               k_q, k_d;
  logic [CFU_REQ_RESP_ID_W-1:0] id_q, id_d;
  logic [CFU_RESP_DATA_W-1:0]   data_q, data_d;
  logic                         err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          id_d = bus.req_id;
          if (bus.req_func_id == '0) begin
            a_d     = bus.req_data0;
            b_d     = bus.req_data1;
            k_d     = '0;
            state_d = ST_CALC;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_CALC: begin
        // The rules are checked in order and the first match wins.
        // The zero tests come first, so gcd(0,x) finishes in one step.
        // k is the common power of two. The shifted result stays within W
        // bits because 2^k divides both original operands.
        if (a_q == '0) begin
          data_d  = CFU_RESP_DATA_W'(b_q << k_q);
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (b_q == '0) begin
          data_d  = CFU_RESP_DATA_W'(a_q << k_q);
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + K_W'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q >= b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_gcd_li3.sv
module tb_gcd_li3;
  localparam int W    = 32;
  localparam int MAXL = 2 * W + 3;

  typedef struct {
    logic [5:0]  id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  gcd_li3_if #(
    .CFU_FUNCTION_ID_W(1),
    .CFU_REQ_RESP_ID_W(6),
    .CFU_REQ_DATA_W(W),
    .CFU_RESP_DATA_W(W)
  ) bus ();

  gcd_li3 #(
    .CFU_FUNCTION_ID_W(1),
    .CFU_REQ_RESP_ID_W(6),
    .CFU_REQ_DATA_W(W),
    .CFU_RESP_DATA_W(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Drives one request from IDLE and pushes its expected response.
  // lat counts the acceptance edge as 1. It returns -1 if resp_valid never rises.
  task automatic issue(input logic [5:0] id, input logic func,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    exp_t e;
    e.id   = id;
    e.data = func ? 32'd0 : ref_gcd(a, b);
    e.err  = func;
    sb.push_back(e);
    bus.req_valid   = 1'b1;
    bus.req_id      = id;
    bus.req_func_id = func;
    bus.req_data0   = a;
    bus.req_data1   = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data0 = $urandom;
    bus.req_data1 = $urandom;
    bus.req_id    = 6'($urandom);
    lat = 1;
    while (!bus.resp_valid && lat < MAXL) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.resp_valid) lat = -1;
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_id !== 6'd0 ||
        bus.resp_data !== 32'd0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b id=%h data=%h err=%b, need 1 0 00 00000000 0",
               bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err);
    end
  endtask

  task automatic test_basic();
    int   lat;
    exp_t e;
    issue(6'd5, 1'b0, 32'd12, 32'd18, lat);
    e = sb.pop_front();
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL basic_timeout: got no resp_valid, need it within %0d cycles", MAXL);
    end
    checks++;
    if (bus.resp_data !== 32'd6 || bus.resp_id !== 6'd5 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_resp: got data=%0d id=%0d err=%b, need 6 5 0",
               bus.resp_data, bus.resp_id, bus.resp_err);
    end
    checks++;
    if (bus.resp_data !== e.data) begin
      errors++;
      $display("FAIL basic_model: got %0d, need %0d", bus.resp_data, e.data);
    end
    consume();
  endtask

  task automatic test_corners();
    logic [31:0] ta[6] = '{32'd0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
    logic [31:0] tb[6] = '{32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
    logic [31:0] tr[6] = '{32'd7, 32'd9, 32'd0, 32'd1, 32'h4000_0000, 32'd1};
    int   lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(6'(10 + i), 1'b0, ta[i], tb[i], lat);
      e = sb.pop_front();
      checks++;
      if (lat < 0) begin
        errors++;
        $display("FAIL corner_timeout[%0d]: got no resp_valid, need within %0d", i, MAXL);
      end
      checks++;
      if (bus.resp_data !== tr[i] || bus.resp_data !== e.data ||
          bus.resp_id !== e.id || bus.resp_err !== 1'b0) begin
        errors++;
        $display("FAIL corner[%0d]: got data=%h id=%0d err=%b, need %h %0d 0",
                 i, bus.resp_data, bus.resp_id, bus.resp_err, tr[i], e.id);
      end
      if (i == 0) begin
        checks++;
        if (lat != 2) begin
          errors++;
          $display("FAIL zero_latency: got %0d, need 2", lat);
        end
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    exp_t        e;
    logic [31:0] d0;
    logic [5:0]  id0;
    issue(6'd33, 1'b0, 32'd1071, 32'd462, lat);
    e   = sb.pop_front();
    d0  = bus.resp_data;
    id0 = bus.resp_id;
    checks++;
    if (lat < 0 || d0 !== 32'd21 || id0 !== e.id) begin
      errors++;
      $display("FAIL bp_resp: got lat=%0d data=%0d id=%0d, need data 21 id %0d",
               lat, d0, id0, e.id);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_data !== d0 ||
          bus.resp_id !== id0 || bus.resp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b data=%0d id=%0d err=%b, need 1 0 %0d %0d 0",
                 c, bus.resp_valid, bus.req_ready, bus.resp_data, bus.resp_id, bus.resp_err, d0, id0);
      end
    end
    consume();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b, need 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_unsupported();
    int   lat;
    exp_t e;
    issue(6'h3F, 1'b1, 32'd100, 32'd75, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL unsup_latency: got %0d, need 1", lat);
    end
    checks++;
    if (bus.resp_err !== e.err || bus.resp_data !== e.data || bus.resp_id !== 6'h3F) begin
      errors++;
      $display("FAIL unsup_resp: got err=%b data=%h id=%h, need 1 00000000 3f",
               bus.resp_err, bus.resp_data, bus.resp_id);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int   lat;
    exp_t e;
    bus.req_valid   = 1'b1;
    bus.req_id      = 6'd44;
    bus.req_func_id = 1'b0;
    bus.req_data0   = 32'd1071;
    bus.req_data1   = 32'd462;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_calc: got rdy=%b vld=%b, need 0 0", bus.req_ready, bus.resp_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_id !== 6'd0 ||
        bus.resp_data !== 32'd0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b vld=%b id=%h data=%h err=%b, need 1 0 00 00000000 0",
               bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err);
    end
    issue(6'd45, 1'b0, 32'd1071, 32'd462, lat);
    e = sb.pop_front();
    checks++;
    if (lat < 0 || bus.resp_data !== 32'd21 || bus.resp_id !== e.id) begin
      errors++;
      $display("FAIL after_reset: got lat=%0d data=%0d id=%0d, need data 21 id %0d",
               lat, bus.resp_data, bus.resp_id, e.id);
    end
    consume();
  endtask

  task automatic test_random();
    logic [31:0] lfsr = 32'hACE1_1234;
    logic [31:0] a, b;
    logic        func;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 40; i++) begin
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      a    = lfsr;
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      b    = lfsr;
      case ($urandom_range(0, 3))
        1: begin a = a & 32'h0000_FFFF; b = b & 32'h0000_0FFF; end
        2: begin a = (a & 32'h0000_0FFF) << 8; b = (b & 32'h0000_0FFF) << 5; end
        3: b = a & 32'h00FF_FF00;
        default: ;
      endcase
      func = ($urandom_range(0, 7) == 0);
      issue(6'(i), func, a, b, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (lat < 0 || bus.resp_valid !== 1'b1 || bus.resp_id !== e.id ||
          bus.resp_data !== e.data || bus.resp_err !== e.err) begin
        errors++;
        $display("FAIL random[%0d]: a=%h b=%h f=%b got lat=%0d id=%0d data=%h err=%b, need id=%0d data=%h err=%b",
                 i, a, b, func, lat, bus.resp_id, bus.resp_data, bus.resp_err, e.id, e.data, e.err);
      end
      consume();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, need 0", sb.size());
    end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_id      = '0;
    bus.req_func_id = '0;
    bus.req_data0   = '0;
    bus.req_data1   = '0;
    bus.resp_ready  = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_unsupported();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
